clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised multi-channel clock-enable/divided-clock generator running from the 100 MHz system clock.
- Each channel has a runtime-programmable divisor and produces two outputs: a one-cycle tick strobe and a 50% square wave.
- Divisor updates are glitch-free: a new divisor is applied only at the channel's terminal count.
- Drives game-logic timers, display scan and animation rates from one block.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, counter and divisor width in bits.
- DEFAULT_DIV, 900000, divisor loaded into every channel at reset. Must be < 2**CNT_W.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select field. Derived; never overridden.

Ports:
- clk, in, 1, system clock (100 MHz).
- rst, in, 1, reset: synchronous, active-high.
- en, in, NUM_CH, per-channel count enable.
- sync, in, 1, restarts the phase of all channels together.
- ld_valid, in, 1, divisor load request.
- ld_ch, in, CH_W, target channel of the load.
- ld_div, in, CNT_W, new divisor value D.
- ld_ready, out, 1, load can be accepted this cycle.
- tick, out, NUM_CH, one-cycle strobe per period.
- sq, out, NUM_CH, square wave output.
- busy, out, NUM_CH, channel has a pending divisor not yet applied.

Behaviour:
- Per-channel state:
  - cnt[CNT_W], counter.
  - act[CNT_W], active divisor.
  - pend[CNT_W], pending divisor.
  - pflag, pending-valid flag.
  - tick_r and sq_r, both registered.
- Reset (rst=1 at a clk edge), all channels:
  - cnt=0, act=DEFAULT_DIV, pflag=0.
  - tick=0, sq=0, busy=0.
  - rst has priority over every other input.
- Period rule:
  - Divisor D gives a tick period of D+1 cycles and a sq period of 2(D+1) cycles.
  - D=0: tick is high every enabled cycle, and sq toggles every cycle.
- Counting, channel i with en[i]=1:
  - If cnt==act: cnt<=0, tick_r<=1, sq_r<=~sq_r. If pflag: act<=pend, pflag<=0.
  - Otherwise: cnt<=cnt+1, tick_r<=0.
  - Latency: after reset or sync with en held high, the first tick is high in the cycle following the (D+1)th rising edge.
- en[i]=0:
  - cnt, sq and act hold; tick_r<=0.
  - A pending divisor stays pending until the next terminal count reached with en high.
- Load handshake:
  - ld_ready = ~pflag[ld_ch].
  - A transfer occurs when ld_valid && ld_ready: pend[ld_ch]<=ld_div, pflag<=1.
  - If ld_ch >= NUM_CH: ld_ready=1 and the request is accepted and discarded, with no state change.
  - busy[i] = pflag[i].
- Load and terminal count in the same cycle:
  - pflag=0 beforehand: the loaded value becomes pending and is applied at the NEXT terminal count.
  - pflag=1 beforehand: ld_ready is already low, so the load is not accepted.
- act never changes mid-period, so cnt never overruns act and no wrap-around check is needed.
- sync=1 (priority below rst, above counting), all channels regardless of en:
  - cnt<=0, tick_r<=0, sq_r<=0.
  - If pflag: act<=pend, pflag<=0.
  - A load accepted in the same cycle as sync is written to pend after that application, i.e. it stays pending.
- Reset mid-operation discards pending loads and restores DEFAULT_DIV.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W_DEF=26 and DEFAULT_DIV_DEF=900000.
  - A function computing the required divisor from a target frequency: D = 100e6/(2*f) - 1.
- Sub-module clk_div_chan, one channel, instantiated NUM_CH times in a generate loop.
  - Its ports: en, sync, wr (decoded load strobe), wdata, tick, sq, busy.
- The top level holds only the channel decode and the ld_ready mux.

Test Plan:
1. DEFAULT_DIV=3, NUM_CH=2, en=2'b11 after reset → tick high every 4th cycle (first high in cycle 4), sq period 8 cycles, both channels in phase.
2. Load D=0 on ch1 mid-period while ch1 act=3 → ch1 finishes its current 4-cycle period, then tick is high continuously and sq toggles every cycle. ch0 is unaffected.
3. Two back-to-back loads to ch0 (D=5, then D=1) → second cycle sees ld_ready=0 and busy[0]=1. The second load is accepted only after the terminal count applies D=5 (period becomes 6).
4. en[0] low for 10 cycles mid-count (cnt=2) → tick[0] stays 0 and sq[0] holds. On re-enable, the first tick comes 2 cycles later (cnt 2→3).
5. sync pulse with ch1 pflag=1 (pend=7) → all cnt=0 and sq=0 next cycle. ch1 act=7 and busy[1]=0 immediately. Next ch1 tick comes 8 cycles later.
6. rst asserted for 1 cycle while a load is pending and sq=1 → next cycle tick=0, sq=0, busy=0, act=DEFAULT_DIV, ld_ready=1. ld_ch=3 with NUM_CH=2 is accepted with no effect.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 26;
    localparam int DEFAULT_DIV_DEF = 900000;
    localparam int SYS_CLK_HZ      = 100_000_000;

    // Divisor that yields a square wave of f_hz on the sq output.
    // The result is D = SYS_CLK_HZ / (2 * f_hz) - 1. A zero frequency
    // is clamped so that the result is still defined.
    function automatic int unsigned div_for_freq(input int unsigned f_hz);
        int unsigned f;
        f = (f_hz == 0) ? 1 : f_hz;
        return (SYS_CLK_HZ / (2 * f)) - 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: a counter, an active and a pending divisor, a tick
// strobe and a square-wave output. The pending divisor is only promoted at
// the terminal count or on sync, so a period is never cut short.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pflag_q, pflag_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // Next-state: sync restarts the phase, otherwise count while enabled.
    // A write lands after any promotion, so it always stays pending.
    always_comb begin
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        tick_d  = 1'b0;
        sq_d    = sq_q;

        if (sync) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (pflag_q) begin
                act_d   = pend_q;
                pflag_d = 1'b0;
            end
        end else if (en) begin
            if (cnt_q == act_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                if (pflag_q) begin
                    act_d   = pend_q;
                    pflag_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (wr) begin
            pend_d  = wdata;
            pflag_d = 1'b1;
        end
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            act_q   <= CNT_W'(DEFAULT_DIV);
            pflag_q <= 1'b0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pflag_q <= pflag_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
        end
    end

    // Pending divisor data; only meaningful while pflag_q is set.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign busy = pflag_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / divided-clock generator. The top level only
// decodes the load channel and muxes the ready flag; each channel does the
// counting on its own.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter int   DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              ld_valid,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [CNT_W-1:0]  ld_div,
    output logic              ld_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] wr;

    // Ready follows the target channel's pending flag; channel numbers past
    // NUM_CH are always ready and simply swallow the request.
    always_comb begin
        ld_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld_ch == CH_W'(i)) begin
                ld_ready = ~busy[i];
            end
        end
    end

    // Decode an accepted load into a one-hot write strobe.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = ld_valid && ld_ready && (ld_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .en    (en[g]),
            .sync  (sync),
            .wr    (wr[g]),
            .wdata (ld_div),
            .tick  (tick[g]),
            .sq    (sq[g]),
            .busy  (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed stimulus with literal expectations, plus
// a period/phase model compared against the outputs every cycle.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DEF    = 3;
    localparam int CH_W   = 2;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              ld_valid;
    logic [CH_W-1:0]   ld_ch;
    logic [CNT_W-1:0]  ld_div;
    logic              ld_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] busy;

    int checks   = 0;
    int failures = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (ld_div),
        .ld_ready (ld_ready),
        .tick     (tick),
        .sq       (sq),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each channel tracks its position inside the current period,
    // the period length (divisor + 1), a queued next divisor, and the
    // number of periods completed since the last restart; sq is the parity
    // of that number.
    // ------------------------------------------------------------------
    int m_pos   [NUM_CH];
    int m_div   [NUM_CH];
    int m_next  [NUM_CH];
    bit m_queued[NUM_CH];
    int m_done  [NUM_CH];
    bit m_tick  [NUM_CH];
    bit started = 0;

    function automatic bit m_ready(input int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_queued[ch];
    endfunction

    always @(posedge clk) begin
        bit take;
        int tch;
        logic [NUM_CH-1:0] e_tick, e_sq, e_busy;
        tch  = int'(ld_ch);
        take = ld_valid && m_ready(tch);
        if (rst) begin
            started = 1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pos[i] = 0; m_div[i] = DEF; m_queued[i] = 0;
                m_done[i] = 0; m_tick[i] = 0;
            end
        end else if (started) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_tick[i] = 0;
                if (sync) begin
                    m_pos[i] = 0; m_done[i] = 0;
                    if (m_queued[i]) begin m_div[i] = m_next[i]; m_queued[i] = 0; end
                end else if (en[i]) begin
                    // Position counts 1..div+1 within the period; the tick
                    // fires on the last cycle of the period.
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == m_div[i] + 1) begin
                        m_tick[i] = 1; m_pos[i] = 0; m_done[i]++;
                        if (m_queued[i]) begin m_div[i] = m_next[i]; m_queued[i] = 0; end
                    end
                end
            end
            if (take && tch < NUM_CH) begin
                m_next[tch] = int'(ld_div);
                m_queued[tch] = 1;
            end
        end
        #1;
        if (started) begin
            for (int i = 0; i < NUM_CH; i++) begin
                e_tick[i] = m_tick[i];
                e_sq[i]   = m_done[i][0];
                e_busy[i] = m_queued[i];
            end
            chk("model_tick", 32'(tick), 32'(e_tick));
            chk("model_sq", 32'(sq), 32'(e_sq));
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("model_ld_ready", 32'(ld_ready), 32'(m_ready(int'(ld_ch))));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus, driven on the falling edge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
    endtask

    // Count falling edges until tick[ch] is seen, bounded by limit.
    task automatic tick_wait(input int ch, input int limit, input int required, input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[ch] && n < limit);
        if (!tick[ch]) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=none required=%0d", name, required);
        end else begin
            chk(name, 32'(n), 32'(required));
        end
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = '0; sync = 1'b0;
        ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
        cyc(); cyc();
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_sq", 32'(sq), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ld_ready", 32'(ld_ready), 32'h1);

        // Default divisor 3: tick every 4th cycle, sq period 8, in phase.
        rst = 1'b0; en = 3'b011;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t1_tick", 32'(tick[1:0]), (k % 4 == 0) ? 32'h3 : 32'h0);
            chk("t1_sq", 32'(sq[1:0]), (k >= 4 && k < 8) ? 32'h3 : 32'h0);
        end

        // Load D=0 on ch1 mid-period.
        cyc();
        ld_valid = 1'b1; ld_ch = 2'd1; ld_div = 8'd0;
        #1 chk("t2_ready", 32'(ld_ready), 32'h1);
        cyc();
        ld_valid = 1'b0;
        chk("t2_busy", 32'(busy), 32'h2);
        chk("t2_old_period", 32'(tick[1]), 32'h0);
        cyc();
        cyc();
        chk("t2_tick_k12", 32'(tick[1:0]), 32'h3);
        chk("t2_sq1_k12", 32'(sq[1]), 32'h1);
        chk("t2_busy_k12", 32'(busy), 32'h0);
        cyc();
        chk("t2_tick_k13", 32'(tick[1:0]), 32'h2);
        chk("t2_sq1_k13", 32'(sq[1]), 32'h0);
        cyc();
        chk("t2_tick_k14", 32'(tick[1:0]), 32'h2);
        chk("t2_sq1_k14", 32'(sq[1]), 32'h1);

        // Back-to-back loads to ch0: D=5 then D=1.
        ld_valid = 1'b1; ld_ch = 2'd0; ld_div = 8'd5;
        #1 chk("t3_ready_first", 32'(ld_ready), 32'h1);
        cyc();
        ld_div = 8'd1;
        #1 chk("t3_ready_second", 32'(ld_ready), 32'h0);
        chk("t3_busy0", 32'(busy[0]), 32'h1);
        cyc();
        chk("t3_tc_tick", 32'(tick[0]), 32'h1);
        chk("t3_tc_busy", 32'(busy[0]), 32'h0);
        chk("t3_tc_ready", 32'(ld_ready), 32'h1);
        cyc();
        ld_valid = 1'b0;
        chk("t3_second_taken", 32'(busy[0]), 32'h1);
        tick_wait(0, 20, 5, "t3_period6");
        tick_wait(0, 20, 2, "t3_period2");

        // Pause ch0 at cnt=2 for 10 cycles.
        ld_valid = 1'b1; ld_ch = 2'd0; ld_div = 8'd3;
        cyc();
        ld_valid = 1'b0;
        cyc();
        chk("t4_tick_apply", 32'(tick[0]), 32'h1);
        cyc();
        cyc();
        en = 3'b010;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t4_hold_tick", 32'(tick[0]), 32'h0);
            chk("t4_hold_sq", 32'(sq[0]), 32'h1);
        end
        en = 3'b011;
        tick_wait(0, 20, 2, "t4_resume");

        // sync with ch1 holding a pending divisor of 7.
        en = 3'b001;
        ld_valid = 1'b1; ld_ch = 2'd1; ld_div = 8'd7;
        #1 chk("t5_ready", 32'(ld_ready), 32'h1);
        cyc();
        ld_valid = 1'b0; sync = 1'b1;
        chk("t5_pending", 32'(busy[1]), 32'h1);
        cyc();
        sync = 1'b0;
        chk("t5_sq", 32'(sq), 32'h0);
        chk("t5_tick", 32'(tick), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        en = 3'b011;
        tick_wait(1, 30, 8, "t5_period8");

        // Reset while a load is pending and sq is high.
        ld_valid = 1'b1; ld_ch = 2'd1; ld_div = 8'd2;
        cyc();
        ld_valid = 1'b0;
        chk("t6_pending", 32'(busy[1]), 32'h1);
        chk("t6_sq_high", 32'(sq[1]), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_tick", 32'(tick), 32'h0);
        chk("t6_sq", 32'(sq), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        #1 chk("t6_ready", 32'(ld_ready), 32'h1);
        ld_valid = 1'b1; ld_ch = 2'd3; ld_div = 8'd0;
        #1 chk("t6_oob_ready", 32'(ld_ready), 32'h1);
        cyc();
        ld_valid = 1'b0;
        chk("t6_oob_busy", 32'(busy), 32'h0);
        tick_wait(1, 20, 3, "t6_default_first");
        tick_wait(1, 20, 4, "t6_default_period");
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
